// File: rtl/eval_scheduler.sv
// Round-robin front end sharing one evaluate_general among NUM_REQ requesters, one evaluation in flight.
// Grant in IDLE is combinational; rsp_* hold under rsp_ready backpressure; WAIT abandons after TIMEOUT cycles.
`timescale 1ns/1ps
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module eval_scheduler #(
  parameter int EVAL_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*`BOARD_WIDTH-1:0]    req_board,
  input  logic [NUM_REQ-1:0]                 req_white_to_move,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               ev_board_valid,
  output logic [`BOARD_WIDTH-1:0]            ev_board,
  output logic                               ev_white_to_move,
  output logic                               ev_clear_eval,
  input  logic                               ev_eval_valid,
  input  logic signed [EVAL_WIDTH-1:0]       ev_eval_mg,
  input  logic signed [EVAL_WIDTH-1:0]       ev_eval_eg,
  input  logic                               ev_insufficient_material,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]         rsp_id,
  output logic signed [EVAL_WIDTH-1:0]       rsp_eval_mg,
  output logic signed [EVAL_WIDTH-1:0]       rsp_eval_eg,
  output logic                               rsp_insufficient,
  output logic                               rsp_error,
  output logic [15:0]                        timeout_count
);

  localparam int BW    = `BOARD_WIDTH;
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  logic [2:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic [ID_W:0]    scan;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_last;

  // Circular search for the first requesting bit at or after rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (scan >= (ID_W + 1)'(NUM_REQ)) begin
        scan = scan - (ID_W + 1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[scan[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[ID_W-1:0];
      end
    end
  end

  // Outputs are gated by reset so they read as idle while reset is held low.
  assign req_ready      = (reset && state == S_IDLE && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign ev_board_valid = reset && (state == S_ISSUE || state == S_WAIT);
  assign ev_clear_eval  = !reset || state == S_CLEAR;
  assign rsp_valid      = reset && state == S_RESP;
  assign wait_last      = (wait_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      wait_cnt         <= '0;
      timeout_count    <= '0;
      ev_board         <= '0;
      ev_white_to_move <= 1'b0;
      rsp_id           <= '0;
      rsp_eval_mg      <= '0;
      rsp_eval_eg      <= '0;
      rsp_insufficient <= 1'b0;
      rsp_error        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            ev_board         <= req_board[BW*grant_idx +: BW];
            ev_white_to_move <= req_white_to_move[grant_idx];
            rsp_id           <= grant_idx;
            rr_ptr           <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // A result landing on the final WAIT cycle still wins over the timeout.
          if (ev_eval_valid) begin
            rsp_eval_mg      <= ev_eval_mg;
            rsp_eval_eg      <= ev_eval_eg;
            rsp_insufficient <= ev_insufficient_material;
            rsp_error        <= 1'b0;
            state            <= S_RESP;
          end else if (wait_last) begin
            rsp_eval_mg      <= '0;
            rsp_eval_eg      <= '0;
            rsp_insufficient <= 1'b0;
            rsp_error        <= 1'b1;
            if (timeout_count != 16'hFFFF) begin
              timeout_count <= timeout_count + 16'd1;
            end
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_CLEAR;
          end
        end
        S_CLEAR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eval_scheduler.sv
// Scoreboard bench for eval_scheduler: stimulus queues expected grants/responses, a negedge monitor checks them.
`timescale 1ns/1ps
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module tb_eval_scheduler;

  localparam int NR = 4;
  localparam int EW = 16;
  localparam int TO = 32;
  localparam int BW = `BOARD_WIDTH;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] mg;
    logic [15:0] eg;
    logic        ins;
    logic        err;
  } rsp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NR-1:0]          req_valid;
  logic [NR*BW-1:0]       req_board;
  logic [NR-1:0]          req_white_to_move;
  logic [NR-1:0]          req_ready;
  logic                   ev_board_valid;
  logic [BW-1:0]          ev_board;
  logic                   ev_white_to_move;
  logic                   ev_clear_eval;
  logic                   ev_eval_valid;
  logic signed [EW-1:0]   ev_eval_mg;
  logic signed [EW-1:0]   ev_eval_eg;
  logic                   ev_insufficient_material;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_id;
  logic signed [EW-1:0]   rsp_eval_mg;
  logic signed [EW-1:0]   rsp_eval_eg;
  logic                   rsp_insufficient;
  logic                   rsp_error;
  logic [15:0]            timeout_count;

  int   checks = 0;
  int   errors = 0;
  int   exp_grant_q[$];
  rsp_t exp_rsp_q[$];
  int   grant_cnt = 0;
  int   rsp_cnt = 0;
  int   cur_grant = 0;
  int   bv_run = 0;
  int   last_bv = 0;

  int          model_delay = 0;
  logic [15:0] model_mg = '0;
  logic [15:0] model_eg = '0;
  logic        model_ins = 1'b0;

  always #5 clk = ~clk;

  eval_scheduler #(.EVAL_WIDTH(EW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_board(req_board), .req_white_to_move(req_white_to_move),
    .req_ready(req_ready),
    .ev_board_valid(ev_board_valid), .ev_board(ev_board), .ev_white_to_move(ev_white_to_move),
    .ev_clear_eval(ev_clear_eval),
    .ev_eval_valid(ev_eval_valid), .ev_eval_mg(ev_eval_mg), .ev_eval_eg(ev_eval_eg),
    .ev_insufficient_material(ev_insufficient_material),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_eval_mg(rsp_eval_mg), .rsp_eval_eg(rsp_eval_eg),
    .rsp_insufficient(rsp_insufficient), .rsp_error(rsp_error),
    .timeout_count(timeout_count)
  );

  function automatic logic [BW-1:0] board_of(input int r);
    logic [3:0] nib;
    nib = 4'(r + 1);
    return BW'({16{nib}}) ^ BW'(64'hA5A5_5A5A_0F0F_F0F0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_rsp(input int id, input logic [15:0] mg, input logic [15:0] eg,
                          input logic ins, input logic err);
    rsp_t e;
    e.id = 2'(id); e.mg = mg; e.eg = eg; e.ins = ins; e.err = err;
    exp_rsp_q.push_back(e);
  endtask

  // Waits for requester r's accept pulse, then withdraws its request once consumed.
  task automatic wait_grant(input int r);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[r] && n < 300);
    chk("grant_wait", {63'd0, req_ready[r]}, 64'd1);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_cnt < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_wait", {63'd0, rsp_cnt >= target}, 64'd1);
    @(negedge clk);
  endtask

  task automatic issue(input int r, input int dly, input logic [15:0] mg,
                       input logic [15:0] eg, input logic ins);
    model_delay = dly; model_mg = mg; model_eg = eg; model_ins = ins;
    exp_grant_q.push_back(r);
    @(posedge clk);
    #1 req_valid[r] = 1'b1;
    wait_grant(r);
  endtask

  // Evaluator model: answers `model_delay` negedges after the ISSUE cycle; negative means never.
  initial begin
    ev_eval_valid = 1'b0;
    ev_eval_mg = '0;
    ev_eval_eg = '0;
    ev_insufficient_material = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && ev_board_valid) begin
        if (model_delay >= 0) begin
          repeat (model_delay) @(negedge clk);
          ev_eval_valid = 1'b1;
          ev_eval_mg = model_mg;
          ev_eval_eg = model_eg;
          ev_insufficient_material = model_ins;
          @(negedge clk);
          ev_eval_valid = 1'b0;
        end
        for (int n = 0; n < 100 && ev_board_valid; n++) @(negedge clk);
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    int g;
    logic clear_due;
    logic stall_prev;
    logic [35:0] snap;
    rsp_t e;
    clear_due = 1'b0;
    stall_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        clear_due = 1'b0;
        stall_prev = 1'b0;
        bv_run = 0;
      end else begin
        if (req_ready != '0) begin
          if (exp_grant_q.size() == 0) begin
            chk("unexpected_grant", {60'd0, req_ready}, 64'd0);
          end else begin
            g = exp_grant_q.pop_front();
            chk("grant_onehot", {60'd0, req_ready}, 64'd1 << g);
            cur_grant = g;
            grant_cnt++;
          end
        end
        if (rsp_valid) chk("no_grant_during_resp", {60'd0, req_ready}, 64'd0);
        if (ev_board_valid) begin
          chk("ev_board", 64'(ev_board), 64'(board_of(cur_grant)));
          chk("ev_white_to_move", {63'd0, ev_white_to_move}, 64'(cur_grant % 2));
          bv_run++;
        end else if (bv_run != 0) begin
          last_bv = bv_run;
          bv_run = 0;
        end
        if (clear_due) begin
          chk("clear_pulse", {62'd0, ev_clear_eval, ev_board_valid}, 64'd2);
          clear_due = 1'b0;
        end else if (ev_clear_eval) begin
          chk("unexpected_clear", {63'd0, ev_clear_eval}, 64'd0);
        end
        if (rsp_valid && stall_prev) begin
          chk("rsp_stable", {28'd0, rsp_id, rsp_eval_mg, rsp_eval_eg, rsp_insufficient, rsp_error},
              {28'd0, snap});
        end
        stall_prev = rsp_valid && !rsp_ready;
        snap = {rsp_id, rsp_eval_mg, rsp_eval_eg, rsp_insufficient, rsp_error};
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp_q.size() == 0) begin
            chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
          end else begin
            e = exp_rsp_q.pop_front();
            chk("rsp_id", {62'd0, rsp_id}, {62'd0, e.id});
            chk("rsp_eval_mg", {48'd0, rsp_eval_mg}, {48'd0, e.mg});
            chk("rsp_eval_eg", {48'd0, rsp_eval_eg}, {48'd0, e.eg});
            chk("rsp_insufficient", {63'd0, rsp_insufficient}, {63'd0, e.ins});
            chk("rsp_error", {63'd0, rsp_error}, {63'd0, e.err});
          end
          rsp_cnt++;
          clear_due = 1'b1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int r = 0; r < NR; r++) begin
      req_board[r*BW +: BW] = board_of(r);
      req_white_to_move[r] = (r % 2) == 1;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_ev_board_valid", {63'd0, ev_board_valid}, 64'd0);
    chk("rst_ev_clear_eval", {63'd0, ev_clear_eval}, 64'd1);
    chk("rst_ev_board", 64'(ev_board), 64'd0);
    chk("rst_timeout_count", {48'd0, timeout_count}, 64'd0);
    chk("rst_rsp_data", {28'd0, rsp_id, rsp_eval_mg, rsp_eval_eg, rsp_insufficient, rsp_error}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("release_clear_low", {63'd0, ev_clear_eval}, 64'd0);

    // Fairness: all four held high for eight evaluations
    model_delay = 2; model_mg = 16'hFFD8; model_eg = 16'd33; model_ins = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_grant_q.push_back(k % 4);
      push_rsp(k % 4, 16'hFFD8, 16'd33, 1'b0, 1'b0);
    end
    base = grant_cnt;
    @(posedge clk);
    #1 req_valid = 4'b1111;
    for (int n = 0; n < 400 && grant_cnt < base + 8; n++) @(negedge clk);
    chk("fair_grants", 64'(grant_cnt - base), 64'd8);
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(8);

    // Single request from requester 2, answer after 7 cycles
    push_rsp(2, 16'd120, 16'd95, 1'b0, 1'b0);
    issue(2, 7, 16'd120, 16'd95, 1'b0);
    wait_rsp(9);
    chk("single_wait_cycles", 64'(last_bv), 64'd8);

    // Backpressure with a second requester pending
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    push_rsp(1, 16'd77, 16'hFFF4, 1'b0, 1'b0);
    issue(1, 3, 16'd77, 16'hFFF4, 1'b0);
    exp_grant_q.push_back(0);
    push_rsp(0, 16'd77, 16'hFFF4, 1'b0, 1'b0);
    req_valid[0] = 1'b1;
    for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("bp_rsp_held", {63'd0, rsp_valid}, 64'd1);
    chk("bp_no_transfer", 64'(rsp_cnt), 64'd9);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_grant(0);
    wait_rsp(11);

    // Timeout: evaluator never answers
    push_rsp(3, 16'd0, 16'd0, 1'b0, 1'b1);
    issue(3, -1, 16'd0, 16'd0, 1'b0);
    wait_rsp(12);
    chk("timeout_wait_cycles", 64'(last_bv), 64'd33);
    chk("timeout_count_1", {48'd0, timeout_count}, 64'd1);

    // Result arrives on the last WAIT cycle
    push_rsp(1, 16'd5, 16'hFFF9, 1'b1, 1'b0);
    issue(1, 32, 16'd5, 16'hFFF9, 1'b1);
    wait_rsp(13);
    chk("collision_wait_cycles", 64'(last_bv), 64'd33);
    chk("collision_timeout_count", {48'd0, timeout_count}, 64'd1);

    // Reset during WAIT
    issue(2, -1, 16'd0, 16'd0, 1'b0);
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("midrst_ev_board_valid", {63'd0, ev_board_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_timeout_count", {48'd0, timeout_count}, 64'd0);
    chk("midrst_ev_board", 64'(ev_board), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_release_clear", {63'd0, ev_clear_eval}, 64'd0);
    chk("midrst_release_bv", {63'd0, ev_board_valid}, 64'd0);
    model_delay = 4; model_mg = 16'd1; model_eg = 16'd2; model_ins = 1'b0;
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(3);
    push_rsp(0, 16'd1, 16'd2, 1'b0, 1'b0);
    push_rsp(3, 16'd1, 16'd2, 1'b0, 1'b0);
    @(posedge clk);
    #1 req_valid = 4'b1001;
    wait_grant(0);
    wait_grant(3);
    wait_rsp(15);

    repeat (5) @(negedge clk);
    chk("grant_queue_empty", 64'(exp_grant_q.size()), 64'd0);
    chk("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
